// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes and memory-side signals of mem_port_arbiter.
// slave is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              InstReq;
    logic [ADDR_W-1:0] InstAddr;
    logic              InstDone;
    logic [DATA_W-1:0] InstData;
    logic              DataReq;
    logic [ADDR_W-1:0] DataAddr;
    logic [3:0]        DataWe;
    logic [DATA_W-1:0] DataWdata;
    logic              DataDone;
    logic [DATA_W-1:0] DataRdata;
    logic              MemEn;
    logic [ADDR_W-1:0] MemAddr;
    logic [3:0]        MemWe;
    logic [DATA_W-1:0] MemWdata;
    logic [DATA_W-1:0] MemRdata;
    logic              StallF;
    logic              StallM;
    logic              Busy;

    modport slave (
        input  InstReq, InstAddr, DataReq, DataAddr, DataWe, DataWdata, MemRdata,
        output InstDone, InstData, DataDone, DataRdata, MemEn, MemAddr, MemWe, MemWdata,
               StallF, StallM, Busy
    );

    modport master (
        output InstReq, InstAddr, DataReq, DataAddr, DataWe, DataWdata, MemRdata,
        input  InstDone, InstData, DataDone, DataRdata, MemEn, MemAddr, MemWe, MemWdata,
               StallF, StallM, Busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and load/store.
// Define ARB_STARVE_GUARD_EN to let a waiting fetch win after STREAK_MAX consecutive data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 2,
    parameter int STREAK_MAX = 4
) (
    input logic               CPU_CLK,
    input logic               CPU_RST_N,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_ACK, RD_DONE} state_t;

    state_t            state, state_nx;
    logic [2:0]        cnt;
    logic              win_inst;
    logic              req_any, sel_inst, data_wr, issue, force_inst;
    logic [DATA_W-1:0] inst_q, data_q;

    if (RD_LAT < 1 || RD_LAT > 7 || STREAK_MAX < 1 || STREAK_MAX > 15) begin : g_chk
        $error("mem_port_arbiter: RD_LAT or STREAK_MAX out of range");
    end

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] streak;
    assign force_inst = streak == 4'(STREAK_MAX);
    // Only IDLE cycles grant; a data grant with a fetch pending extends the streak.
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N)
        if (!CPU_RST_N) streak <= '0;
        else if (state == IDLE) streak <= (bus.InstReq && !sel_inst) ? streak + 4'd1 : '0;
`else
    assign force_inst = 1'b0;
`endif

    assign req_any  = bus.InstReq | bus.DataReq;
    assign sel_inst = bus.InstReq & (~bus.DataReq | force_inst);
    assign data_wr  = ~sel_inst & (|bus.DataWe);
    // Gated by reset so a held request cannot strobe the memory while in reset.
    assign issue    = CPU_RST_N & (state == IDLE) & req_any;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_any) state_nx = data_wr ? WR_ACK : RD_WAIT;
            RD_WAIT: if (cnt == 3'd1) state_nx = RD_DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state    <= IDLE;
            cnt      <= '0;
            win_inst <= 1'b0;
            inst_q   <= '0;
            data_q   <= '0;
        end else begin
            state <= state_nx;
            if (issue) begin
                win_inst <= sel_inst;
                cnt      <= 3'(RD_LAT);
            end else if (state == RD_WAIT) begin
                cnt <= cnt - 3'd1;
            end
            if (state == RD_WAIT && cnt == 3'd1) begin
                if (win_inst) inst_q <= bus.MemRdata;
                else          data_q <= bus.MemRdata;
            end
        end
    end

    always_comb begin
        bus.MemEn     = issue;
        bus.MemAddr   = issue ? (sel_inst ? bus.InstAddr : bus.DataAddr) : '0;
        bus.MemWe     = (issue && !sel_inst) ? bus.DataWe : 4'b0000;
        bus.MemWdata  = (issue && !sel_inst) ? bus.DataWdata : '0;
        bus.InstDone  = (state == RD_DONE) & win_inst;
        bus.DataDone  = ((state == RD_DONE) & ~win_inst) | (state == WR_ACK);
        bus.InstData  = inst_q;
        bus.DataRdata = data_q;
        bus.StallF    = bus.InstReq & ~bus.InstDone;
        bus.StallM    = bus.DataReq & ~bus.DataDone;
        bus.Busy      = state != IDLE;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-port instruction/data memory between the IF stage (instruction fetch) and the MEM stage (loads/stores) of the RV32 pipeline. It grants one requester at a time, tracks the single outstanding access through the memory's fixed read latency, and returns data with a one-cycle done pulse. It also drives the IF/MEM stall requests consumed by the hazard logic. Byte-write masks use the decoder's MemWrite encoding: 4-bit byte mask, 0000 = read.

## Interface
Parameters:
- ADDR_W, 32, address width (byte address, passed through unchanged)
- DATA_W, 32, data width
- RD_LAT, 2, memory read latency in cycles from MemEn to valid MemRdata; legal 1..7
- STREAK_MAX, 4, maximum consecutive data grants while a fetch waits (guard build only); legal 1..15

Ports:
- CPU_CLK  in  1  clock, rising edge
- CPU_RST_N  in  1  asynchronous, active-low reset
- InstReq  in  1  fetch request, held until InstDone
- InstAddr  in  ADDR_W  fetch address
- InstDone  out  1  one-cycle completion pulse
- InstData  out  DATA_W  fetched word, valid with InstDone, held until the next fetch completes
- DataReq  in  1  load/store request, held until DataDone
- DataAddr  in  ADDR_W  load/store address
- DataWe  in  4  byte mask; 0000 = load; 0001 SB, 0011 SH, 1111 SW
- DataWdata  in  DATA_W  store data
- DataDone  out  1  one-cycle completion pulse
- DataRdata  out  DATA_W  load word, valid with DataDone, held until the next load completes
- MemEn  out  1  memory access strobe, one cycle per access
- MemAddr  out  ADDR_W  memory address
- MemWe  out  4  memory byte-write mask
- MemWdata  out  DATA_W  memory write data
- MemRdata  in  DATA_W  memory read data, valid RD_LAT cycles after a read MemEn
- StallF  out  1  InstReq & ~InstDone
- StallM  out  1  DataReq & ~DataDone
- Busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, RD_WAIT, WR_ACK, RD_DONE.
- IDLE, no request: MemEn=0 and MemWe=0000.
- IDLE, any request: the winner's address, mask, and data are driven combinationally onto the Mem* ports with MemEn=1 in the same cycle. The arbiter latches the winner's ID and the access type.
  - Read (InstReq, or DataReq with DataWe=0000): load the latency counter with RD_LAT and go to RD_WAIT.
  - Write: go to WR_ACK.
- RD_WAIT: decrement the counter each cycle. When it reaches 0, capture MemRdata into the winner's data register and go to RD_DONE.
- RD_DONE: pulse the winner's Done and go to IDLE.
- WR_ACK: pulse DataDone and go to IDLE.
- Arbitration:
  - Only one requester: that requester wins.
  - Both requesters: data wins, because the MEM-stage instruction is older.
- Requester rules:
  - A requester changes or drops Req/Addr only at the edge after its Done.
  - Input changes during an outstanding access are ignored.
  - Done still pulses if Req was dropped mid-access.
- New issue: earliest in the cycle after a Done. There are no back-to-back issues.
- Reset (async, any state):
  - State goes to IDLE, counter to 0, streak to 0.
  - All outputs go to 0: MemEn, MemWe, MemAddr, MemWdata, both Done, both data registers, Busy.
  - StallF/StallM follow their Req inputs, because Done is 0.
  - An in-flight read is abandoned. A late MemRdata is never captured.

## Timing
- Issue cycle T is the first IDLE cycle with a request. MemEn=1 in cycle T only.
- Read: MemRdata is sampled at the end of cycle T+RD_LAT. Done and data are valid in cycle T+RD_LAT+1, so latency is RD_LAT+1 cycles.
- Write: DataDone in cycle T+1.
- Maximum throughput:
  - One read per RD_LAT+2 cycles.
  - One write per 2 cycles.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A 4-bit streak counter increments on each data grant made while InstReq=1.
  - The counter clears on any instruction grant, or in any IDLE cycle with InstReq=0.
  - When the counter equals STREAK_MAX and both requests are pending, the instruction wins.
- Undefined: strict data priority; no streak counter is synthesized.

## Test plan
- Reset: assert CPU_RST_N=0 mid-RD_WAIT with MemRdata=0x12345678. Required: all outputs 0 immediately; state IDLE after release; InstData remains 0.
- Single load, RD_LAT=2: DataReq=1, DataWe=0000, DataAddr=0x100 at T. Required:
  - MemEn=1 and MemAddr=0x100 at T only.
  - MemRdata=0xDEADBEEF at T+2.
  - DataDone=1 and DataRdata=0xDEADBEEF at T+3.
  - StallM=1 for T..T+2.
- Store byte: DataWe=0001, DataAddr=0x203, DataWdata=0xAB at T. Required: MemWe=0001, MemAddr=0x203 at T; DataDone at T+1; no read capture.
- Contention: InstReq and DataReq (load) both rise at T. Required: data issues at T and DataDone at T+3; fetch issues at T+4 and InstDone at T+7.
- Starvation, STREAK_MAX=4, InstReq held, 6 back-to-back loads:
  - With ARB_STARVE_GUARD_EN: the fetch is granted immediately after the 4th load completes.
  - Without it: the fetch is granted after the 6th load completes.
- Req drop mid-read: InstReq falls at T+1. Required: InstDone still pulses at T+3; no second MemEn is issued for it.
